smem_bank_scheduler: RTL and testbench

- Shares one single-port SRAM bank of the CGRA shared memory among N PE requesters.
- Performs per-beat round-robin arbitration with a valid/ready handshake, then drives a registered SRAM command.
- Returns read data through a latency-matched response pipeline, tagged with a one-hot requester ID.
- Sits between the PE load/store ports and one bank macro; one instance per bank.

---
 rtl/smem_sched_pkg.sv | 28 ++
 rtl/smem_bank_scheduler_rr_pick.sv | 39 +++
 rtl/smem_bank_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_smem_bank_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/smem_sched_pkg.sv
// Shared types and constants for the shared-memory bank scheduler.
// The struct widths follow the default bank geometry (SMEM_AW/SMEM_DW).
package smem_sched_pkg;

    localparam int SMEM_AW   = 10;
    localparam int SMEM_DW   = 32;
    localparam int ID_W      = 4;   // binary requester index, covers N up to 16
    localparam int PTR_RST   = 0;
    localparam int BURST_RST = 0;

    // Index width for a population of n items, never narrower than one bit
    function automatic int idxw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                en;
        logic                we;
        logic [SMEM_AW-1:0]  addr;
        logic [SMEM_DW-1:0]  wdata;
    } mem_cmd_t;

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
    } rsp_pipe_t;

endpackage

// File: rtl/smem_bank_scheduler_rr_pick.sv
// Mask-based round-robin picker: a fixed-priority chain over requests at or
// above ptr, falling back to an unmasked chain when none are pending there.
module rr_pick #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [N-1:0]  mask_s;
    logic [N-1:0]  masked_s;
    logic [IW-1:0] m_idx_s;
    logic [IW-1:0] u_idx_s;

    // Lowest pending index in the masked and unmasked sets, then one-hot grant
    always_comb begin
        mask_s   = '0;
        masked_s = '0;
        m_idx_s  = '0;
        u_idx_s  = '0;
        gnt      = '0;
        for (int i = 0; i < N; i++) begin
            mask_s[i] = (i >= int'(ptr));
        end
        masked_s = req & mask_s;
        for (int i = N - 1; i >= 0; i--) begin
            m_idx_s = masked_s[i] ? IW'(i) : m_idx_s;
            u_idx_s = req[i]      ? IW'(i) : u_idx_s;
        end
        gnt_idx = (|masked_s) ? m_idx_s : u_idx_s;
        for (int i = 0; i < N; i++) begin
            gnt[i] = (|req) && (gnt_idx == IW'(i));
        end
    end

endmodule

// File: rtl/smem_bank_scheduler.sv
// One-bank scheduler: round-robin arbitration, registered SRAM command and a
// latency-matched read-response pipeline. Define BURST_LOCK_EN for burst lock.
module smem_bank_scheduler
    import smem_sched_pkg::*;
#(
    parameter int N         = 5,
    parameter int AW        = SMEM_AW,
    parameter int DW        = SMEM_DW,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N-1:0]    req_we,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    input  logic            mem_busy,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic [N-1:0]    rsp_valid,
    output logic [DW-1:0]   rsp_rdata
);

    localparam int IW = idxw(N);

    logic [N-1:0]  gnt_s;
    logic [IW-1:0] gnt_idx_s;
    logic [IW-1:0] ptr_r;
    logic          accept_s;
    mem_cmd_t      cmd_r;
    mem_cmd_t      cmd_nxt_s;
    rsp_pipe_t     pipe_r [RD_LAT];
    rsp_pipe_t     pipe_nxt_s;
    logic [N-1:0]  rsp_dec_s;
    logic [N-1:0]  rsp_valid_r;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(N - 1)) ? '0 : v + IW'(1);
    endfunction

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req     (req_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Grant is withheld during reset and while the bank is busy
    always_comb begin
        req_ready = '0;
        if (rst && !mem_busy) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    assign accept_s = |(req_valid & req_ready);

    // Next SRAM command and response tag from the granted requester
    always_comb begin
        cmd_nxt_s       = cmd_r;
        cmd_nxt_s.en    = 1'b0;
        pipe_nxt_s      = '0;
        if (accept_s) begin
            cmd_nxt_s.en    = 1'b1;
            cmd_nxt_s.we    = req_we[gnt_idx_s];
            cmd_nxt_s.addr  = req_addr[gnt_idx_s*AW +: AW];
            cmd_nxt_s.wdata = req_wdata[gnt_idx_s*DW +: DW];
            pipe_nxt_s.valid = !req_we[gnt_idx_s];
            pipe_nxt_s.id    = ID_W'(gnt_idx_s);
        end else begin
            cmd_nxt_s.en = 1'b0;
        end
    end

    // Registered SRAM command
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_r <= '0;
        end else begin
            cmd_r <= cmd_nxt_s;
        end
    end

    // Read tags travel RD_LAT stages to meet the SRAM data
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_r[k] <= '0;
            end
        end else begin
            pipe_r[0] <= pipe_nxt_s;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    // Decode the last stage tag into a one-hot strobe
    always_comb begin
        rsp_dec_s = '0;
        for (int i = 0; i < N; i++) begin
            rsp_dec_s[i] = pipe_r[RD_LAT-1].valid && (pipe_r[RD_LAT-1].id == ID_W'(i));
        end
    end

    // Registered response strobe, aligned with mem_rdata
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_r <= '0;
        end else begin
            rsp_valid_r <= rsp_dec_s;
        end
    end

    // Data passes straight from the macro so it lands in the strobe cycle
    always_comb begin
        rsp_rdata = '0;
        if (|rsp_valid_r) begin
            rsp_rdata = mem_rdata;
        end else begin
            rsp_rdata = '0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign mem_en    = cmd_r.en;
    assign mem_we    = cmd_r.we;
    assign mem_addr  = cmd_r.addr;
    assign mem_wdata = cmd_r.wdata;

`ifdef BURST_LOCK_EN
    localparam int BW = idxw(MAX_BURST);

    logic [BW-1:0] burst_r;
    logic [BW-1:0] cnt_cur_s;
    logic [IW-1:0] last_r;

    // A grant to someone other than the locked requester starts a fresh run
    assign cnt_cur_s = (gnt_idx_s == last_r) ? burst_r : '0;

    // Pointer stays on the locked requester until the run ends or it drops
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r   <= IW'(PTR_RST);
            burst_r <= BW'(BURST_RST);
            last_r  <= IW'(PTR_RST);
        end else if (accept_s) begin
            last_r <= gnt_idx_s;
            if (cnt_cur_s < BW'(MAX_BURST - 1)) begin
                burst_r <= cnt_cur_s + BW'(1);
                ptr_r   <= gnt_idx_s;
            end else begin
                burst_r <= BW'(BURST_RST);
                ptr_r   <= wrap_inc(gnt_idx_s);
            end
        end else if (!mem_busy && (burst_r != BW'(BURST_RST))) begin
            burst_r <= BW'(BURST_RST);
            ptr_r   <= wrap_inc(last_r);
        end else begin
            burst_r <= burst_r;
            ptr_r   <= ptr_r;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = (MAX_BURST > 0);

    // Strict per-beat rotation
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r <= IW'(PTR_RST);
        end else if (accept_s) begin
            ptr_r <= wrap_inc(gnt_idx_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

endmodule

// File: tb/tb_smem_bank_scheduler.sv
// Directed bench for smem_bank_scheduler: vector table plus corner sequences,
// with a small SRAM model and a response expectation queue.
module tb_smem_bank_scheduler;

    localparam int N      = 5;
    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            mem_busy;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;

    smem_bank_scheduler #(.N(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_busy(mem_busy), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [AW-1:0] a_tab [N];
    logic [DW-1:0] wd_tab [N];
    logic [DW-1:0] mem [1024];

    typedef struct {
        int          due;
        logic [N-1:0] id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [N-1:0] valid;
        logic         busy;
        logic [N-1:0] exp_ready;
    } vec_t;
    vec_t tbl [15];

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model, one-cycle read latency
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic repack();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a_tab[i];
            req_wdata[i*DW +: DW] = wd_tab[i];
        end
    endtask

    // Response monitor: every strobe must match the head of the queue
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", DW'(rsp_valid), DW'(q[0].id));
            chk("rsp_rdata", rsp_rdata, q[0].data);
            void'(q.pop_front());
        end else begin
            chk("rsp_idle", DW'(rsp_valid), '0);
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] we, input logic busy,
                        input logic [N-1:0] exp_rdy, input logic track,
                        input logic [DW-1:0] rd_exp, input string nm);
        int idx;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        mem_busy  = busy;
        #1;
        chk({nm, "_ready"}, DW'(req_ready), DW'(exp_rdy));
        idx = oh2i(exp_rdy);
        if (track && exp_rdy != '0 && !we[idx])
            q.push_back('{cyc + RD_LAT + 1, exp_rdy, rd_exp});
        @(posedge clk);
        #1;
        chk({nm, "_mem_en"}, DW'(mem_en), DW'(exp_rdy != '0));
        if (exp_rdy != '0) begin
            chk({nm, "_mem_addr"}, DW'(mem_addr), DW'(a_tab[idx]));
            chk({nm, "_mem_we"}, DW'(mem_we), DW'(we[idx]));
            if (we[idx]) chk({nm, "_mem_wdata"}, mem_wdata, wd_tab[idx]);
        end
    endtask

`ifdef BURST_LOCK_EN
    localparam int SEQ_N = 9;
    logic [N-1:0] seq [SEQ_N] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001,
                                  5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00001};
`else
    localparam int SEQ_N = 4;
    logic [N-1:0] seq [SEQ_N] = '{5'b00001, 5'b00100, 5'b00001, 5'b00100};
`endif

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = 32'hC0DE_0000 | DW'(a);
        for (int i = 0; i < N; i++) begin
            a_tab[i]  = AW'(10'h040 + i);
            wd_tab[i] = {16'hBEEF, 16'(i)};
        end
        repack();
        rst = 1'b0; req_valid = '1; req_we = '0; mem_busy = 1'b0;

        // Reset with every requester asserting valid
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_ready", DW'(req_ready), '0);
        chk("rst_mem_en", DW'(mem_en), '0);
        chk("rst_mem_we", DW'(mem_we), '0);
        chk("rst_mem_addr", DW'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        rst = 1'b1; #1;
        chk("rel_ready", DW'(req_ready), 32'h1);
        req_valid = '0;

        tbl[0]  = '{5'b11111, 1'b0, 5'b00001};
        tbl[1]  = '{5'b11111, 1'b0, 5'b00010};
        tbl[2]  = '{5'b11111, 1'b0, 5'b00100};
        tbl[3]  = '{5'b11111, 1'b0, 5'b01000};
        tbl[4]  = '{5'b11111, 1'b0, 5'b10000};
        tbl[5]  = '{5'b11111, 1'b0, 5'b00001};
        tbl[6]  = '{5'b00100, 1'b0, 5'b00100};
        tbl[7]  = '{5'b00101, 1'b0, 5'b00001};
        tbl[8]  = '{5'b00101, 1'b0, 5'b00100};
        tbl[9]  = '{5'b01000, 1'b1, 5'b00000};
        tbl[10] = '{5'b01000, 1'b1, 5'b00000};
        tbl[11] = '{5'b01000, 1'b1, 5'b00000};
        tbl[12] = '{5'b01000, 1'b0, 5'b01000};
        tbl[13] = '{5'b00000, 1'b0, 5'b00000};
        tbl[14] = '{5'b10001, 1'b0, 5'b10000};
        for (int r = 0; r < 15; r++) begin
            step(tbl[r].valid, '0, tbl[r].busy, tbl[r].exp_ready, 1'b1,
                 32'hC0DE_0000 | DW'(a_tab[oh2i(tbl[r].exp_ready)]), $sformatf("tbl%0d", r));
        end

        // Write then read back the same word by requester 1
        a_tab[1] = 10'h155; wd_tab[1] = 32'hA5A5_0001; repack();
        step(5'b00010, 5'b00010, 1'b0, 5'b00010, 1'b1, '0, "wr");
        step(5'b00010, 5'b00000, 1'b0, 5'b00010, 1'b1, 32'hA5A5_0001, "rd");
        step(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, '0, "idle0");
        step(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, '0, "idle1");

        // Reset while a read is in flight: its response must vanish
        step(5'b00100, 5'b00000, 1'b0, 5'b00100, 1'b0, '0, "flight");
        @(negedge clk);
        rst = 1'b0; req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_rst_ready", DW'(req_ready), '0);
        chk("mid_rst_mem_en", DW'(mem_en), '0);
        chk("mid_rst_mem_addr", DW'(mem_addr), '0);
        rst = 1'b1; #1;
        chk("mid_rel_ready", DW'(req_ready), 32'h1);
        req_valid = '0;

        // Requesters 0 and 2 permanently valid from ptr 0
        for (int s = 0; s < SEQ_N; s++) begin
            step(5'b00101, 5'b00000, 1'b0, seq[s], 1'b1,
                 32'hC0DE_0000 | DW'(a_tab[oh2i(seq[s])]), $sformatf("seq%0d", s));
        end
        step(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, '0, "drain0");
        step(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, '0, "drain1");
        chk("queue_empty", DW'(q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
